// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg -- shared constants and types for the instruction fetch front end.
//   PC_W_DEF       default PC / branch-target width
//   NOP            instruction word used for IF/ID bubbles
//   RESET_VEC_DEF  default PC after reset
//   TRAP_VEC_DEF   default PC loaded on a misaligned redirect
//                  (only used when PC_MISALIGN_TRAP_EN is defined)
//   pc_sel_e       which source feeds the next PC
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int          PC_W_DEF      = 32;
  localparam logic [31:0] NOP           = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;

  // Encoded in priority order, lowest first.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register with flush, hold and load.
//   clk, reset     clock, synchronous active-high reset
//   flush_i        load a bubble (NOP, pc/pc4 = 0, valid = 0); wins over hold
//   hold_i         keep every output unchanged
//   pc_i, pc4_i    PC of the fetched instruction and that PC + 4
//   instr_i        fetched instruction word
//   pc_o, pc4_o, instr_o, valid_o   registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_reg
  import mips_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] pc4_i,
  input  logic [31:0]     instr_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc4_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      pc_d    = pc_i;
      pc4_d   = pc4_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage -- PC register, next-PC select and IF/ID register.
//   clk, reset                 clock, synchronous active-high reset
//   stall                      hold PC and IF/ID (hazard)
//   branch_taken, branch_target  highest-priority redirect
//   jump, jump_target          second-priority redirect
//   imem_addr / imem_rdata     combinational instruction memory port
//   if_id_pc, if_id_pc4, if_id_instr, if_id_valid   IF/ID contents
//   fetch_count                instructions written valid into IF/ID
//   misalign_exc               one-cycle pulse on a misaligned redirect
//
// Build option: define PC_MISALIGN_TRAP_EN to trap misaligned redirect
// targets to TRAP_VEC. Without it, target bits [1:0] are simply cleared
// and misalign_exc stays 0.
//
// Flow control: there is no valid/ready handshake here. stall freezes the
// stage for the cycle it is high; a redirect in the same cycle still wins
// and flushes IF/ID.
// ---------------------------------------------------------------------------
module pc_fetch_stage
  import mips_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(TRAP_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [31:0]     fetch_count,
  output logic            misalign_exc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] raw_target;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect;
  logic            load_ifid;
  logic [31:0]     fetch_count_q, fetch_count_d;
  pc_sel_e         pc_sel;

  assign redirect   = branch_taken | jump;
  assign raw_target = branch_taken ? branch_target : jump_target;
  assign pc_plus4   = pc_q + PC_W'(4);   // wraps modulo 2^PC_W
  assign load_ifid  = !redirect && !stall;

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_exc_q;

  assign misaligned  = redirect && (raw_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VEC : raw_target;

  always_ff @(posedge clk) begin
    if (reset) misalign_exc_q <= 1'b0;
    else       misalign_exc_q <= misaligned;
  end

  assign misalign_exc = misalign_exc_q;
`else
  // Low target bits are dropped, so they and the trap vector go unread.
  logic unused_no_trap;
  assign unused_no_trap = ^{TRAP_VEC, raw_target[1:0]};

  assign redirect_pc  = {raw_target[PC_W-1:2], 2'b00};
  assign misalign_exc = 1'b0;
`endif

  always_comb begin
    pc_sel = SEL_SEQ;
    if (branch_taken) pc_sel = SEL_BRANCH;
    else if (jump)    pc_sel = SEL_JUMP;
    else if (stall)   pc_sel = SEL_HOLD;

    pc_d = pc_plus4;
    case (pc_sel)
      SEL_BRANCH, SEL_JUMP: pc_d = redirect_pc;
      SEL_HOLD:             pc_d = pc_q;
      default:              pc_d = pc_plus4;
    endcase

    fetch_count_d = load_ifid ? fetch_count_q + 32'd1 : fetch_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VEC;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .PC_W (PC_W)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .hold_i  (stall),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .instr_i (imem_rdata),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = fetch_count_q;

endmodule
